mux_share_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for a shared 2:1 mux datapath (a `_GGMUX2`-style path whose select has non-zero propagation delay).
- Grants the mux to one requester at a time and drives the mux select.
- After every select change it inserts a programmable settle interval before granting, so downstream logic never samples a mux output in transition.
- Enforces round-robin fairness and a maximum burst length per grant.

---
 rtl/mux_share_arbiter_if.sv | 30 +++
 rtl/mux_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_share_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mux_share_arbiter_if.sv
// Bus between two requesters and the mux_share_arbiter.
//   req0/req1   : request, held high while data is pending
//   last0/last1 : final beat of the current burst (only meaningful while granted)
//   gnt0/gnt1   : registered grants, mutually exclusive
//   sel         : registered mux select (0 = requester 0, 1 = requester 1)
//   beat        : one transfer through the mux this cycle
//   busy        : arbiter not idle
//   burst_cnt   : beats completed in the current grant
interface mux_share_arbiter_if;
  logic       req0;
  logic       req1;
  logic       last0;
  logic       last1;
  logic       gnt0;
  logic       gnt1;
  logic       sel;
  logic       beat;
  logic       busy;
  logic [7:0] burst_cnt;

  modport slave (
    input  req0, req1, last0, last1,
    output gnt0, gnt1, sel, beat, busy, burst_cnt
  );

  modport master (
    output req0, req1, last0, last1,
    input  gnt0, gnt1, sel, beat, busy, burst_cnt
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter for a shared 2:1 mux whose select has
// propagation delay. After every select change a SETTLE-cycle dead interval
// is inserted before the grant; each grant is limited to MAX_BURST beats.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : requester/grant bundle (slave side), see mux_share_arbiter_if
module mux_share_arbiter #(
  parameter int unsigned MAX_BURST = 4,   // 1..255
  parameter int unsigned SETTLE    = 2    // 0..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_share_arbiter_if.slave    bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OWN    = 2'd2;

  localparam logic [7:0] MAX_B      = 8'(MAX_BURST);
  localparam bit         HAS_SETTLE = (SETTLE != 0);
  localparam logic [3:0] STL_INIT   = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;

  logic [1:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       busy_q, busy_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [3:0] stl_cnt_q, stl_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;

  logic beat;
  logic req_own;
  logic last_own;
  logic burst_end;
  logic do_arb;
  logic arb_prio;
  logic any_req;
  logic winner;

  always_comb begin
    beat      = (gnt0_q & bus.req0) | (gnt1_q & bus.req1);
    req_own   = owner_q ? bus.req1  : bus.req0;
    last_own  = owner_q ? bus.last1 : bus.last0;
    burst_end = (state_q == ST_OWN) &
                ((last_own & beat) |
                 (((burst_cnt_q + 8'd1) == MAX_B) & beat) |
                 ~req_own);
    do_arb    = (state_q == ST_IDLE) | burst_end;
    // At burst end the priority update must already be visible to this
    // edge's arbitration, so use the post-update value directly.
    arb_prio  = (state_q == ST_OWN) ? ~owner_q : prio_q;
    any_req   = bus.req0 | bus.req1;
    winner    = (bus.req0 & bus.req1) ? arb_prio : bus.req1;

    state_d     = state_q;
    sel_d       = sel_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    stl_cnt_d   = stl_cnt_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      ST_SETTLE: begin
        if (stl_cnt_q != 4'd0) begin
          stl_cnt_d = stl_cnt_q - 4'd1;
        end else begin
          state_d     = ST_OWN;
          gnt0_d      = ~owner_q;
          gnt1_d      = owner_q;
          burst_cnt_d = '0;
        end
      end
      ST_OWN: begin
        if (burst_end) begin
          prio_d = ~owner_q;
        end else if (beat) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    if (do_arb) begin
      burst_cnt_d = '0;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      if (!any_req) begin
        state_d = ST_IDLE;
      end else begin
        owner_d = winner;
        sel_d   = winner;
        if ((winner == sel_q) || !HAS_SETTLE) begin
          state_d = ST_OWN;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
        end else begin
          state_d   = ST_SETTLE;
          stl_cnt_d = STL_INIT;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      stl_cnt_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      busy_q      <= busy_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      stl_cnt_q   <= stl_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sel       = sel_q;
  assign bus.beat      = beat;
  assign bus.busy      = busy_q;
  assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Randomized bench for mux_share_arbiter: two instances (MAX_BURST=4/SETTLE=2
// and MAX_BURST=3/SETTLE=0) share a clock and reset, each driven with its own
// random request pattern and compared every cycle to a grant-schedule model.
module tb_mux_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_share_arbiter_if u_if0 ();
  mux_share_arbiter_if u_if1 ();

  mux_share_arbiter #(.MAX_BURST(4), .SETTLE(2)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if0.slave)
  );

  mux_share_arbiter #(.MAX_BURST(3), .SETTLE(0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // holder: requester currently granted (-1 none); pend: requester waiting
  // for the mux to settle; wl: settle cycles still to wait after this one.
  int holder[2];
  int pend[2];
  int wl[2];
  int cnt[2];
  bit msel[2];
  bit mprio[2];

  // stimulus currently driven
  bit r0[2], r1[2], l0[2], l1[2];
  int mode[2];

  function automatic int max_burst(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int settle(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int pick(input bit a, input bit b, input bit p);
    if (a && b) return p ? 1 : 0;
    if (a)      return 0;
    if (b)      return 1;
    return -1;
  endfunction

  task automatic grant_to(input int d, input int w);
    cnt[d] = 0;
    if (w < 0) begin
      holder[d] = -1;
    end else if (w == int'(msel[d]) || settle(d) == 0) begin
      msel[d]   = bit'(w);
      holder[d] = w;
    end else begin
      msel[d]   = bit'(w);
      holder[d] = -1;
      pend[d]   = w;
      wl[d]     = settle(d) - 1;
    end
  endtask

  task automatic model_edge(input int d, input bit rst);
    int  h;
    bit  rq, ls;
    if (!rst) begin
      holder[d] = -1; pend[d] = -1; wl[d] = 0; cnt[d] = 0;
      msel[d] = 1'b0; mprio[d] = 1'b0;
    end else if (holder[d] >= 0) begin
      h  = holder[d];
      rq = (h == 1) ? r1[d] : r0[d];
      ls = (h == 1) ? l1[d] : l0[d];
      if (!rq || ls || (cnt[d] + 1 == max_burst(d))) begin
        mprio[d] = (h == 0);
        grant_to(d, pick(r0[d], r1[d], mprio[d]));
      end else begin
        cnt[d]++;
      end
    end else if (pend[d] >= 0) begin
      if (wl[d] > 0) begin
        wl[d]--;
      end else begin
        holder[d] = pend[d];
        pend[d]   = -1;
        cnt[d]    = 0;
      end
    end else begin
      grant_to(d, pick(r0[d], r1[d], mprio[d]));
    end
  endtask

  task automatic check_regs(input int d, input logic g0, input logic g1,
                            input logic s, input logic b, input logic [7:0] c);
    string p;
    p = (d == 0) ? "d0" : "d1";
    check({p, ".gnt0"},      int'(g0), int'(holder[d] == 0));
    check({p, ".gnt1"},      int'(g1), int'(holder[d] == 1));
    check({p, ".sel"},       int'(s),  int'(msel[d]));
    check({p, ".busy"},      int'(b),  int'(holder[d] >= 0 || pend[d] >= 0));
    check({p, ".burst_cnt"}, int'(c),  cnt[d]);
  endtask

  task automatic check_beat(input int d, input logic bt);
    int exp;
    exp = 0;
    if (holder[d] == 0) exp = int'(r0[d]);
    if (holder[d] == 1) exp = int'(r1[d]);
    check((d == 0) ? "d0.beat" : "d1.beat", int'(bt), exp);
  endtask

  task automatic drive();
    u_if0.req0 = r0[0]; u_if0.req1 = r1[0]; u_if0.last0 = l0[0]; u_if0.last1 = l1[0];
    u_if1.req0 = r0[1]; u_if1.req1 = r1[1]; u_if1.last0 = l0[1]; u_if1.last1 = l1[1];
  endtask

  task automatic randomize_inputs(input int d);
    case (mode[d])
      0: begin
        if ($urandom_range(0, 7) == 0) r0[d] = ~r0[d];
        if ($urandom_range(0, 7) == 0) r1[d] = ~r1[d];
      end
      1: begin
        r0[d] = 1'b1; r1[d] = 1'b1;
      end
      2: begin
        r0[d] = 1'b0; r1[d] = 1'b1;
      end
      default: begin
        r0[d] = bit'($urandom_range(0, 1));
        r1[d] = bit'($urandom_range(0, 1));
      end
    endcase
    l0[d] = ($urandom_range(0, 5) == 0);
    l1[d] = ($urandom_range(0, 5) == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0, rst_n);
    model_edge(1, rst_n);
    #1;
    check_regs(0, u_if0.gnt0, u_if0.gnt1, u_if0.sel, u_if0.busy, u_if0.burst_cnt);
    check_regs(1, u_if1.gnt0, u_if1.gnt1, u_if1.sel, u_if1.busy, u_if1.burst_cnt);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      r0[d] = 0; r1[d] = 0; l0[d] = 0; l1[d] = 0; mode[d] = 0;
    end
    drive();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    check_beat(0, u_if0.beat);
    check_beat(1, u_if1.beat);
    // a few idle cycles with no requests
    for (int i = 0; i < 4; i++) cycle();

    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        mode[0] = $urandom_range(0, 3);
        mode[1] = $urandom_range(0, 3);
      end
      randomize_inputs(0);
      randomize_inputs(1);
      rst_n = ($urandom_range(0, 299) != 0);
      drive();
      #1;
      check_beat(0, u_if0.beat);
      check_beat(1, u_if1.beat);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
